// File: rtl/logic_axi4_stream_arbiter.sv
`default_nettype none
// ============================================================================
// logic_axi4_stream_arbiter - packet-locked round-robin merge of INPUTS
// AXI4-Stream requesters onto a single output link.          Rev 1.0
// ============================================================================
module logic_axi4_stream_arbiter #(
  parameter int INPUTS      = 2,
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH   = 1,
  parameter bit USE_TKEEP   = 1'b1,
  parameter bit USE_TSTRB   = 1'b1,
  parameter bit USE_TLAST   = 1'b1
) (
  input  logic                            aclk,
  input  logic                            areset_n,
  input  logic [INPUTS-1:0]               rx_tvalid,
  output logic [INPUTS-1:0]               rx_tready,
  input  logic [INPUTS*TDATA_BYTES*8-1:0] rx_tdata,
  input  logic [INPUTS*TDATA_BYTES-1:0]   rx_tkeep,
  input  logic [INPUTS*TDATA_BYTES-1:0]   rx_tstrb,
  input  logic [INPUTS-1:0]               rx_tlast,
  input  logic [INPUTS*TDEST_WIDTH-1:0]   rx_tdest,
  input  logic [INPUTS*TUSER_WIDTH-1:0]   rx_tuser,
  input  logic [INPUTS*TID_WIDTH-1:0]     rx_tid,
  output logic                            tx_tvalid,
  input  logic                            tx_tready,
  output logic [TDATA_BYTES*8-1:0]        tx_tdata,
  output logic [TDATA_BYTES-1:0]          tx_tkeep,
  output logic [TDATA_BYTES-1:0]          tx_tstrb,
  output logic                            tx_tlast,
  output logic [TDEST_WIDTH-1:0]          tx_tdest,
  output logic [TUSER_WIDTH-1:0]          tx_tuser,
  output logic [TID_WIDTH-1:0]            tx_tid,
  output logic [$clog2(INPUTS)-1:0]       grant,
  output logic                            busy
);

  localparam int DW = TDATA_BYTES * 8;
  localparam int KW = TDATA_BYTES;
  localparam int GW = $clog2(INPUTS);
  localparam logic [GW-1:0] LAST_IDX = GW'(INPUTS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;

  logic            sel_valid;
  logic [DW-1:0]   sel_data;
  logic [KW-1:0]   sel_keep;
  logic [KW-1:0]   sel_strb;
  logic            sel_last;
  logic [TDEST_WIDTH-1:0] sel_dest;
  logic [TUSER_WIDTH-1:0] sel_user;
  logic [TID_WIDTH-1:0]   sel_id;

  logic            pick_hi_found;
  logic [GW-1:0]   pick_hi;
  logic [GW-1:0]   pick_lo;
  logic [GW-1:0]   pick;
  logic            pkt_end;

  // Payload always follows rx[grant_q] so tx never carries X, even in IDLE.
  always_comb begin
    sel_valid = rx_tvalid[0];
    sel_data  = rx_tdata[DW-1:0];
    sel_keep  = rx_tkeep[KW-1:0];
    sel_strb  = rx_tstrb[KW-1:0];
    sel_last  = rx_tlast[0];
    sel_dest  = rx_tdest[TDEST_WIDTH-1:0];
    sel_user  = rx_tuser[TUSER_WIDTH-1:0];
    sel_id    = rx_tid[TID_WIDTH-1:0];
    for (int i = 1; i < INPUTS; i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = rx_tvalid[i];
        sel_data  = rx_tdata[i*DW +: DW];
        sel_keep  = rx_tkeep[i*KW +: KW];
        sel_strb  = rx_tstrb[i*KW +: KW];
        sel_last  = rx_tlast[i];
        sel_dest  = rx_tdest[i*TDEST_WIDTH +: TDEST_WIDTH];
        sel_user  = rx_tuser[i*TUSER_WIDTH +: TUSER_WIDTH];
        sel_id    = rx_tid[i*TID_WIDTH +: TID_WIDTH];
      end
    end
  end

  // Round-robin: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    pick_hi_found = 1'b0;
    pick_hi       = '0;
    pick_lo       = '0;
    for (int i = INPUTS - 1; i >= 0; i--) begin
      if (rx_tvalid[i]) begin
        pick_lo = GW'(i);
        if (GW'(i) >= ptr_q) begin
          pick_hi       = GW'(i);
          pick_hi_found = 1'b1;
        end
      end
    end
    pick = pick_hi_found ? pick_hi : pick_lo;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    tx_tvalid = 1'b0;
    rx_tready = '0;
    pkt_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|rx_tvalid) begin
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        tx_tvalid = sel_valid;
        for (int i = 0; i < INPUTS; i++) begin
          rx_tready[i] = (grant_q == GW'(i)) && tx_tready;
        end
        pkt_end = sel_valid && tx_tready && (sel_last || !USE_TLAST);
        if (pkt_end) begin
          state_d = IDLE;
          ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Disabled sideband reads as all-ones, the AXI4-Stream default.
  assign tx_tdata = sel_data;
  assign tx_tkeep = sel_keep | {KW{~USE_TKEEP}};
  assign tx_tstrb = sel_strb | {KW{~USE_TSTRB}};
  assign tx_tlast = sel_last;
  assign tx_tdest = sel_dest;
  assign tx_tuser = sel_user;
  assign tx_tid   = sel_id;
  assign busy     = (state_q == LOCKED);
  assign grant    = grant_q;

endmodule
`default_nettype wire
